// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipe_stage_buf skid-buffered pipeline stage.
//   buf_state_t      : occupancy of the two-slot buffer (EMPTY / ONE / FULL)
//   NOP_INST_DEFAULT : instruction word used as the flush bubble by default
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0020;

endpackage

// File: rtl/pipe_stage_buf_stage_slot.sv
// stage_slot: load-enabled register holding one {bubble, pc_4, inst} entry.
//   clk, rst_n                  : clock, async active-low reset (clears entry)
//   load                        : capture d_* on the rising edge
//   d_bubble, d_pc_4, d_inst    : entry to capture
//   q_bubble, q_pc_4, q_inst    : held entry
module stage_slot #(
  parameter int unsigned PC_W   = 9,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              d_bubble,
  input  logic [PC_W-1:0]   d_pc_4,
  input  logic [INST_W-1:0] d_inst,
  output logic              q_bubble,
  output logic [PC_W-1:0]   q_pc_4,
  output logic [INST_W-1:0] q_inst
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_bubble <= 1'b0;
      q_pc_4   <= '0;
      q_inst   <= '0;
    end else if (load) begin
      q_bubble <= d_bubble;
      q_pc_4   <= d_pc_4;
      q_inst   <= d_inst;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: one-cycle pipeline stage with a skid slot so in_ready can be
// registered (no combinational path from out_ready to in_ready).
//   clk, rst_n        : clock, async active-low reset
//   flush             : discard held entries (optionally leaving a NOP bubble)
//   in_valid/in_ready : upstream handshake; in_ready is registered
//   in_pc_4, in_inst  : upstream entry
//   out_valid/out_ready : downstream handshake
//   out_pc_4, out_inst, out_bubble : head entry (zero when out_valid=0)
//   bubble_cnt        : saturating count of flush bubbles inserted
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       PC_W         = 9,
  parameter int unsigned       INST_W       = 32,
  parameter logic [INST_W-1:0] NOP_INST     = INST_W'(NOP_INST_DEFAULT),
  parameter bit                FLUSH_BUBBLE = 1'b1,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc_4,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc_4,
  output logic [INST_W-1:0] out_inst,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  bubble_cnt
);

  buf_state_t state_q, state_n;
  logic       in_ready_q;

  logic              main_load, skid_load;
  logic              main_d_bubble, skid_d_bubble;
  logic [PC_W-1:0]   main_d_pc_4, skid_d_pc_4;
  logic [INST_W-1:0] main_d_inst, skid_d_inst;
  logic              main_bubble, skid_bubble;
  logic [PC_W-1:0]   main_pc_4, skid_pc_4;
  logic [INST_W-1:0] main_inst, skid_inst;

  logic push, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  assign out_pc_4   = out_valid ? main_pc_4   : '0;
  assign out_inst   = out_valid ? main_inst   : '0;
  assign out_bubble = out_valid ? main_bubble : 1'b0;

  always_comb begin
    state_n       = state_q;
    main_load     = 1'b0;
    main_d_bubble = 1'b0;
    main_d_pc_4   = in_pc_4;
    main_d_inst   = in_inst;
    skid_load     = 1'b0;
    skid_d_bubble = 1'b0;
    skid_d_pc_4   = in_pc_4;
    skid_d_inst   = in_inst;

    if (flush) begin
      skid_load   = 1'b1;
      skid_d_pc_4 = '0;
      skid_d_inst = '0;
      main_load   = 1'b1;
      main_d_pc_4 = '0;
      if (FLUSH_BUBBLE) begin
        main_d_bubble = 1'b1;
        main_d_inst   = NOP_INST;
        state_n       = ST_ONE;
      end else begin
        main_d_inst = '0;
        state_n     = ST_EMPTY;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_load = 1'b1;
            state_n   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            skid_load = 1'b1;
            state_n   = ST_FULL;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can occur: skid advances to main
          if (pop) begin
            main_load     = 1'b1;
            main_d_bubble = skid_bubble;
            main_d_pc_4   = skid_pc_4;
            main_d_inst   = skid_inst;
            state_n       = ST_ONE;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      state_q    <= state_n;
      in_ready_q <= (state_n != ST_FULL);
      if (flush && FLUSH_BUBBLE && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  stage_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (main_load),
    .d_bubble (main_d_bubble),
    .d_pc_4   (main_d_pc_4),
    .d_inst   (main_d_inst),
    .q_bubble (main_bubble),
    .q_pc_4   (main_pc_4),
    .q_inst   (main_inst)
  );

  stage_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .d_bubble (skid_d_bubble),
    .d_pc_4   (skid_d_pc_4),
    .d_inst   (skid_d_inst),
    .q_bubble (skid_bubble),
    .q_pc_4   (skid_pc_4),
    .q_inst   (skid_inst)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances share one stimulus stream
// (default, FLUSH_BUBBLE=0, CNT_W=2); each section checks the relevant ones.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [8:0]  in_pc_4;
  logic [31:0] in_inst;

  logic        a_in_ready, a_out_valid, a_out_bubble;
  logic [8:0]  a_out_pc_4;
  logic [31:0] a_out_inst;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_out_bubble;
  logic [8:0]  b_out_pc_4;
  logic [31:0] b_out_inst;
  logic [15:0] b_cnt;

  logic        c_in_ready, c_out_valid, c_out_bubble;
  logic [8:0]  c_out_pc_4;
  logic [31:0] c_out_inst;
  logic [1:0]  c_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc_4(in_pc_4), .in_inst(in_inst),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc_4(a_out_pc_4),
    .out_inst(a_out_inst), .out_bubble(a_out_bubble), .bubble_cnt(a_cnt)
  );

  pipe_stage_buf #(.FLUSH_BUBBLE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc_4(in_pc_4), .in_inst(in_inst),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc_4(b_out_pc_4),
    .out_inst(b_out_inst), .out_bubble(b_out_bubble), .bubble_cnt(b_cnt)
  );

  pipe_stage_buf #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_pc_4(in_pc_4), .in_inst(in_inst),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_pc_4(c_out_pc_4),
    .out_inst(c_out_inst), .out_bubble(c_out_bubble), .bubble_cnt(c_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc_4  = pc;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc_4 = '0; in_inst = '0;

    // reset state
    #2;
    chk("rst_valid",  64'(a_out_valid),  64'd0);
    chk("rst_ready",  64'(a_in_ready),   64'd0);
    chk("rst_pc",     64'(a_out_pc_4),   64'd0);
    chk("rst_inst",   64'(a_out_inst),   64'd0);
    chk("rst_bubble", 64'(a_out_bubble), 64'd0);
    chk("rst_cnt",    64'(a_cnt),        64'd0);
    step(); step();
    chk("rst_hold_ready", 64'(a_in_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(a_in_ready), 64'd1);

    // single transfer, latency 1
    out_ready = 1'b1;
    push(9'd4, 32'h8C01_0000);
    chk("x1_valid", 64'(a_out_valid), 64'd1);
    chk("x1_pc",    64'(a_out_pc_4),  64'd4);
    chk("x1_inst",  64'(a_out_inst),  64'h8C01_0000);
    chk("x1_bub",   64'(a_out_bubble), 64'd0);
    step();
    chk("x1_gone_valid", 64'(a_out_valid), 64'd0);
    chk("x1_gone_inst",  64'(a_out_inst),  64'd0);
    chk("x1_gone_pc",    64'(a_out_pc_4),  64'd0);

    // stall: fill to FULL, extra input must be refused
    out_ready = 1'b0;
    push(9'd8, 32'h1111_1111);
    chk("st_one_ready", 64'(a_in_ready), 64'd1);
    chk("st_one_inst",  64'(a_out_inst), 64'h1111_1111);
    push(9'd12, 32'h2222_2222);
    chk("st_full_ready", 64'(a_in_ready), 64'd0);
    chk("st_full_inst",  64'(a_out_inst), 64'h1111_1111);
    chk("st_full_pc",    64'(a_out_pc_4), 64'd8);
    push(9'd16, 32'h3333_3333);
    chk("st_hold_inst",  64'(a_out_inst), 64'h1111_1111);
    chk("st_hold_valid", 64'(a_out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("drain_b_inst",  64'(a_out_inst), 64'h2222_2222);
    chk("drain_b_pc",    64'(a_out_pc_4), 64'd12);
    chk("drain_b_ready", 64'(a_in_ready), 64'd1);
    step();
    chk("drain_empty", 64'(a_out_valid), 64'd0);

    // flush while FULL with a competing push
    out_ready = 1'b0;
    push(9'd20, 32'h4444_4444);
    push(9'd24, 32'h5555_5555);
    chk("fl_pre_full", 64'(b_in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_pc_4 = 9'd28; in_inst = 32'h6666_6666;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid",  64'(a_out_valid),  64'd1);
    chk("fl_inst",   64'(a_out_inst),   64'h20);
    chk("fl_pc",     64'(a_out_pc_4),   64'd0);
    chk("fl_bubble", 64'(a_out_bubble), 64'd1);
    chk("fl_cnt",    64'(a_cnt),        64'd1);
    chk("fl_ready",  64'(a_in_ready),   64'd1);
    chk("fl0_valid", 64'(b_out_valid),  64'd0);
    chk("fl0_inst",  64'(b_out_inst),   64'd0);
    chk("fl0_ready", 64'(b_in_ready),   64'd1);
    chk("fl0_cnt",   64'(b_cnt),        64'd0);
    out_ready = 1'b1;
    step();
    chk("fl_bubble_popped", 64'(a_out_valid), 64'd0);
    chk("fl0_still_empty",  64'(b_out_valid), 64'd0);

    // counter saturation: four more flushes -> 5 total
    flush = 1'b1;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b0;
    chk("sat_cnt2",  64'(c_cnt), 64'd3);
    chk("cnt16",     64'(a_cnt), 64'd5);
    step();

    // reset while FULL
    out_ready = 1'b0;
    push(9'd32, 32'h7777_7777);
    push(9'd36, 32'h8888_8888);
    chk("rf_full_ready", 64'(a_in_ready), 64'd0);
    rst_n = 1'b0;
    #2;
    chk("rf_valid", 64'(a_out_valid), 64'd0);
    chk("rf_ready", 64'(a_in_ready),  64'd0);
    chk("rf_cnt",   64'(a_cnt),       64'd0);
    chk("rf_inst",  64'(a_out_inst),  64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rf_rel_ready", 64'(a_in_ready),  64'd1);
    chk("rf_rel_valid", 64'(a_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter PC_W, default 9, width of pc_4 field.
REQ-002 SHALL have parameter INST_W, default 32, width of instruction field.
REQ-003 SHALL have parameter NOP_INST, default 32'h0000_0020, instruction word inserted as a bubble on flush.
REQ-004 SHALL have parameter FLUSH_BUBBLE, default 1: 1 means flush leaves a valid bubble, 0 means flush empties the stage.
REQ-005 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 flush  input  1  discard all held entries.
REQ-010 in_valid  input  1  upstream holds an entry.
REQ-011 in_ready  output  1  stage can accept; registered.
REQ-012 in_pc_4  input  PC_W  upstream pc+4.
REQ-013 in_inst  input  INST_W  upstream instruction.
REQ-014 out_valid  output  1  out_* fields are valid.
REQ-015 out_ready  input  1  downstream accepts; low means stall.
REQ-016 out_pc_4  output  PC_W  head pc+4.
REQ-017 out_inst  output  INST_W  head instruction.
REQ-018 out_bubble  output  1  head entry is a flush bubble.
REQ-019 bubble_cnt  output  CNT_W  saturating count of bubbles inserted.

Function
REQ-020 SHALL hold two slots, MAIN (drives out_*) and SKID, with state EMPTY, ONE (MAIN full) or FULL (both full).
REQ-021 in_ready SHALL be 1 exactly when the state is not FULL, taken from a register with no combinational path from out_ready.
REQ-022 A push SHALL be in_valid&&in_ready; a pop SHALL be out_valid&&out_ready.
REQ-023 SHALL have a latency of 1 cycle: an entry pushed into EMPTY appears on out_* the next cycle.
REQ-024 EMPTY: a push SHALL load MAIN and go to ONE.
REQ-025 ONE: push with pop SHALL load MAIN and stay in ONE.
REQ-026 ONE: push without pop SHALL load SKID and go to FULL.
REQ-027 ONE: pop without push SHALL go to EMPTY.
REQ-028 FULL: a pop SHALL move SKID to MAIN and go to ONE; no push is possible in FULL.
REQ-029 Order SHALL be strictly FIFO; no entry is duplicated or lost except by flush.
REQ-030 With out_ready low, out_* SHALL stay stable while out_valid is 1.
REQ-031 flush SHALL take priority over push and pop; a push in the same cycle is dropped.
REQ-032 On flush, SKID SHALL be cleared.
REQ-033 On flush with FLUSH_BUBBLE=1, MAIN SHALL become {pc_4=0, inst=NOP_INST, bubble=1}, the state ONE, and bubble_cnt SHALL increment.
REQ-034 On flush with FLUSH_BUBBLE=0, the state SHALL become EMPTY.
REQ-035 A bubble SHALL pop like any other entry.
REQ-036 bubble_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-037 An entry with out_valid=0 SHALL drive out_pc_4, out_inst and out_bubble as 0.

Reset
REQ-038 Reset SHALL force state EMPTY, in_ready=0, out_valid=0, out_pc_4=0, out_inst=0, out_bubble=0 and bubble_cnt=0.
REQ-039 Reset SHALL take effect immediately, including mid-transfer; in_ready SHALL rise the first clock after release.

Structure
REQ-040 The shared package SHALL hold the state enum (EMPTY/ONE/FULL) and the default NOP_INST constant.
REQ-041 One sub-module, stage_slot, SHALL be the load-enabled register for {bubble, pc_4, inst} and SHALL be instantiated twice.

Verification
REQ-042 Push pc=4, inst=0x8C010000 with out_ready=1 -> next cycle out_valid=1 with the same values; following cycle out_valid=0.
REQ-043 out_ready=0, push A then B -> state FULL, in_ready=0, out_* holds A; out_ready=1 -> A then B on consecutive cycles.
REQ-044 FULL plus flush with in_valid=1 (FLUSH_BUBBLE=1) -> next cycle out_inst=0x20, out_pc_4=0, out_bubble=1, bubble_cnt=1, input dropped.
REQ-045 Same case with FLUSH_BUBBLE=0 -> out_valid=0, state EMPTY.
REQ-046 CNT_W=2, 5 flushes -> bubble_cnt=3.
REQ-047 Assert rst_n low while FULL -> out_valid=0 at once; in_ready=1 the first clock after release.
